seq_normalizer: RTL and testbench

- Multi-cycle leading-zero normalizer: the inverse of the combinational barrel shifter.
- Accepts a WIDTH-bit word and finds the leading-zero count by binary search, one stage per clock.
- Returns the left-justified word plus the shift amount, so D_OUT == D_IN << LZ_AMT.
- Sits in front of the barrel shifter in the normalize/denormalize datapath. Valid/ready handshakes on both sides.

---
 rtl/seq_normalizer.sv | 151 +++++++++++++++
 tb/tb_seq_normalizer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_normalizer.sv
// Sequential leading-zero normalizer.
// Takes a WIDTH-bit word, finds its leading-zero count by binary search (one
// stage per clock), and returns the left-justified word plus the shift applied,
// so o_d_out == i_d_in << o_lz_amt. An all-zero input reports WIDTH-1 and o_zero.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   i_d_in holds a word to normalize
//   o_in_ready   block accepts a word (IDLE only, low while i_rst_n=0)
//   i_d_in       word to normalize
//   o_out_valid  result valid
//   i_out_ready  consumer accepts the result
//   o_d_out      normalized word (MSB set unless o_zero)
//   o_lz_amt     leading-zero count / left-shift amount applied
//   o_zero       input word was all zeros
module seq_normalizer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_d_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_d_out,
  output logic [AMT_W-1:0] o_lz_amt,
  output logic             o_zero
);

  localparam int unsigned HALF_W = WIDTH / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_amt;
  logic [AMT_W-1:0] r_step;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_d_out;
  logic [AMT_W-1:0] r_lz_amt;
  logic             r_zero;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_work_nxt;
  logic [AMT_W-1:0] w_amt_nxt;
  logic [AMT_W-1:0] w_step_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_d_out_nxt;
  logic [AMT_W-1:0] w_lz_amt_nxt;
  logic             w_zero_nxt;

  logic [WIDTH-1:0] w_top_mask;
  logic             w_top_zero;
  logic [WIDTH-1:0] w_work_stage;
  logic [AMT_W-1:0] w_amt_stage;

  // One search stage: shift by step when the top step bits are all zero.
  always_comb begin
    w_top_mask   = ~({WIDTH{1'b1}} >> r_step);
    w_top_zero   = ((r_work & w_top_mask) == '0);
    w_work_stage = r_work;
    w_amt_stage  = r_amt;
    if (w_top_zero) begin
      w_work_stage = r_work << r_step;
      w_amt_stage  = r_amt + r_step;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_amt_nxt       = r_amt;
    w_step_nxt      = r_step;
    w_out_valid_nxt = r_out_valid;
    w_d_out_nxt     = r_d_out;
    w_lz_amt_nxt    = r_lz_amt;
    w_zero_nxt      = r_zero;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_state_nxt = S_SEARCH;
          w_work_nxt  = i_d_in;
          w_amt_nxt   = '0;
          w_step_nxt  = AMT_W'(HALF_W);
        end
      end
      S_SEARCH: begin
        w_work_nxt = w_work_stage;
        w_amt_nxt  = w_amt_stage;
        w_step_nxt = r_step >> 1;
        // The step=1 stage is the last; its result goes straight to the outputs.
        if (r_step == AMT_W'(1)) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_d_out_nxt     = w_work_stage;
          w_lz_amt_nxt    = w_amt_stage;
          w_zero_nxt      = (w_work_stage == '0);
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_amt       <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_d_out     <= '0;
      r_lz_amt    <= '0;
      r_zero      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_amt       <= w_amt_nxt;
      r_step      <= w_step_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_d_out     <= w_d_out_nxt;
      r_lz_amt    <= w_lz_amt_nxt;
      r_zero      <= w_zero_nxt;
    end
  end

  // Ready comes from the state register, gated so it drops as soon as reset asserts.
  assign o_in_ready  = (r_state == S_IDLE) && i_rst_n;
  assign o_out_valid = r_out_valid;
  assign o_d_out     = r_d_out;
  assign o_lz_amt    = r_lz_amt;
  assign o_zero      = r_zero;

endmodule

// File: tb/tb_seq_normalizer.sv
// Randomized and directed bench for seq_normalizer against a leading-zero model.
module tb_seq_normalizer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMT_W = 5;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] i_d_in;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_d_out;
  logic [AMT_W-1:0] o_lz_amt;
  logic             o_zero;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  seq_normalizer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_d_in      (i_d_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_d_out     (o_d_out),
    .o_lz_amt    (o_lz_amt),
    .o_zero      (o_zero)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: count leading zeros directly; all-zero input reports WIDTH-1.
  function automatic void ref_norm(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] n,
                                   output int lz, output logic z);
    if (d == '0) begin
      n = '0; lz = WIDTH - 1; z = 1'b1;
    end else begin
      lz = 0;
      while (d[WIDTH-1-lz] == 1'b0) lz++;
      n = d << lz;
      z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // One transaction from IDLE; stall = cycles of OUT_READY=0 once the result is up.
  task automatic do_txn(input logic [WIDTH-1:0] d, input int stall, output int acc_cyc);
    logic [WIDTH-1:0] en;
    int               elz;
    logic             ez;
    int               wait_c;
    ref_norm(d, en, elz, ez);
    check("in_ready_idle", 32'(o_in_ready), 32'd1);
    i_in_valid  = 1'b1;
    i_d_in      = d;
    i_out_ready = (stall == 0);
    tick();
    acc_cyc    = cyc_cnt;
    i_in_valid = 1'b0;
    wait_c = 0;
    while (!o_out_valid && wait_c < 20) begin
      check("in_ready_busy", 32'(o_in_ready), 32'd0);
      tick();
      wait_c++;
    end
    check("latency", 32'(wait_c), 32'(AMT_W));
    check("d_out", o_d_out, en);
    check("lz_amt", 32'(o_lz_amt), 32'(elz));
    check("zero", 32'(o_zero), 32'(ez));
    check("excl_ready", 32'(o_in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      // Pulse a second word mid-stall; it must not be queued.
      i_in_valid = (s == 1);
      i_d_in     = (s == 1) ? 32'h1 : d;
      tick();
      check("hold_valid", 32'(o_out_valid), 32'd1);
      check("hold_d_out", o_d_out, en);
      check("hold_lz", 32'(o_lz_amt), 32'(elz));
      check("hold_ready", 32'(o_in_ready), 32'd0);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    tick();
    check("post_valid", 32'(o_out_valid), 32'd0);
    check("post_hold_d", o_d_out, en);
    check("post_ready", 32'(o_in_ready), 32'd1);
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check(tag, 32'(o_out_valid), 32'd0);
    end
  endtask

  initial begin
    int acc, prev_acc;
    logic [WIDTH-1:0] rd;
    i_rst_n     = 1'b0;
    i_in_valid  = 1'b1;
    i_d_in      = 32'hFFFF_FFFF;
    i_out_ready = 1'b1;

    // Reset with a valid word present.
    repeat (3) tick();
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_d_out", o_d_out, 32'd0);
    check("rst_lz", 32'(o_lz_amt), 32'd0);
    check("rst_zero", 32'(o_zero), 32'd0);
    i_in_valid = 1'b0;
    i_rst_n    = 1'b1;
    tick();
    check("rel_in_ready", 32'(o_in_ready), 32'd1);

    // Directed basics.
    do_txn(32'h0001_2345, 0, acc);
    check("basic_d", o_d_out, 32'h91A2_8000);
    check("basic_lz", 32'(o_lz_amt), 32'd15);
    do_txn(32'h8000_0000, 0, acc);
    check("msb_lz", 32'(o_lz_amt), 32'd0);

    // Single-bit sweep at full rate.
    prev_acc = -1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      do_txn(32'd1 << i, 0, acc);
      check("sweep_lz", 32'(o_lz_amt), 32'(WIDTH - 1 - i));
      check("sweep_d", o_d_out, 32'h8000_0000);
      if (prev_acc >= 0) check("sweep_period", 32'(acc - prev_acc), 32'd7);
      prev_acc = acc;
    end

    // Zero input.
    do_txn(32'h0, 0, acc);
    check("zero_lz", 32'(o_lz_amt), 32'd31);
    check("zero_flag", 32'(o_zero), 32'd1);

    // Backpressure with a dropped mid-stall pulse.
    do_txn(32'h0000_F000, 10, acc);
    check("bp_d", o_d_out, 32'hF000_0000);
    check("bp_lz", 32'(o_lz_amt), 32'd16);
    idle_quiet("bp_dropped", 8);

    // Mid-operation reset.
    i_in_valid = 1'b1;
    i_d_in     = 32'h1;
    tick();
    i_in_valid = 1'b0;
    tick();
    i_rst_n = 1'b0;
    #1;
    check("midrst_ready_low", 32'(o_in_ready), 32'd0);
    tick();
    check("midrst_valid", 32'(o_out_valid), 32'd0);
    i_rst_n = 1'b1;
    idle_quiet("midrst_no_emit", 8);
    do_txn(32'h3, 0, acc);
    check("midrst_lz", 32'(o_lz_amt), 32'd30);
    check("midrst_d", o_d_out, 32'hC000_0000);

    // Randomized words with varied leading-zero counts and stalls.
    for (int r = 0; r < 40; r++) begin
      rd = $urandom() >> $urandom_range(0, WIDTH - 1);
      do_txn(rd, int'($urandom_range(0, 3)), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
